// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the two-master data-memory arbiter.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StAck
  } arb_state_e;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  // Wide enough for read latencies 1..7.
  localparam int unsigned CntW = 3;

endpackage

// File: rtl/rr_pick2.sv
// Combinational 2-way selector: single requester wins, ties go by priority or round-robin.
module rr_pick2
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_i,
  input  logic       prio_m0_i,
  output logic       gnt_id_o,
  output logic       any_o
);

  // Winner decode; on a tie round-robin favours the master not granted last.
  always_comb begin
    any_o    = |req_i;
    gnt_id_o = M0;
    case (req_i)
      2'b01:   gnt_id_o = M0;
      2'b10:   gnt_id_o = M1;
      2'b11:   gnt_id_o = prio_m0_i ? M0 : ~last_i;
      default: gnt_id_o = M0;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-master arbiter serialising accesses onto a single data-memory port.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned MEM_LAT = 1,
  parameter int unsigned PRIO_M0 = 0
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          m0_req,
  input  logic          m0_wen,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_ack,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_wen,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_ack,
  output logic [DW-1:0] m1_rdata,
  output logic          mem_en,
  output logic          mem_wen,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  localparam logic            PrioM0Bit = (PRIO_M0 != 0);
  localparam logic [CntW-1:0] CntOne    = CntW'(1);
  localparam logic [CntW-1:0] CntLoad   = CntW'(MEM_LAT);

  arb_state_e      state_q, state_d;
  logic            id_q, id_d;
  logic            wen_q, wen_d;
  logic            last_q, last_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [DW-1:0]   rdata0_q, rdata0_d;
  logic [DW-1:0]   rdata1_q, rdata1_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            pick_id;
  logic            pick_any;

  rr_pick2 u_pick (
    .req_i    ({m1_req, m0_req}),
    .last_i   (last_q),
    .prio_m0_i(PrioM0Bit),
    .gnt_id_o (pick_id),
    .any_o    (pick_any)
  );

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (pick_any) state_d = StIssue;
      StIssue: state_d = wen_q ? StAck : StWait;
      StWait:  if (cnt_q == CntOne) state_d = StAck;
      StAck:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath next values: latch the winner's request, count latency, capture read data.
  always_comb begin
    id_d     = id_q;
    wen_d    = wen_q;
    last_d   = last_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    cnt_d    = cnt_q;
    if (state_q == StIdle && pick_any) begin
      id_d   = pick_id;
      last_d = pick_id;
      if (pick_id == M1) begin
        wen_d   = m1_wen;
        addr_d  = m1_addr;
        wdata_d = m1_wdata;
      end else begin
        wen_d   = m0_wen;
        addr_d  = m0_addr;
        wdata_d = m0_wdata;
      end
    end
    if (state_q == StIssue && !wen_q) begin
      cnt_d = CntLoad;
    end
    if (state_q == StWait) begin
      cnt_d = cnt_q - CntOne;
      if (cnt_q == CntOne) begin
        if (id_q == M1) begin
          rdata1_d = mem_rdata;
        end else begin
          rdata0_d = mem_rdata;
        end
      end
    end
  end

  // Datapath registers; an in-flight transfer is simply dropped on reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      id_q     <= M0;
      wen_q    <= 1'b0;
      last_q   <= M1;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      cnt_q    <= '0;
    end else begin
      id_q     <= id_d;
      wen_q    <= wen_d;
      last_q   <= last_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      cnt_q    <= cnt_d;
    end
  end

  // Outputs decoded from registered state only, so no path from req to ack or mem_*.
  always_comb begin
    mem_en    = (state_q == StIssue);
    mem_wen   = (state_q == StIssue) && wen_q;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    m0_ack    = (state_q == StAck) && (id_q == M0);
    m1_ack    = (state_q == StAck) && (id_q == M1);
    m0_rdata  = rdata0_q;
    m1_rdata  = rdata1_q;
    busy      = (state_q != StIdle);
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomised bench: instance 0 is round-robin with MEM_LAT=1, instance 1 is fixed-priority
// with MEM_LAT=3. Expected grants and timing come from a transaction-level model.
module tb_dmem_arbiter;

  logic        clk;
  logic        rstn;
  logic [1:0]  m_req   [2];
  logic [1:0]  m_wen   [2];
  logic [31:0] m_addr  [2][2];
  logic [31:0] m_wdata [2][2];
  logic [31:0] m_rdata [2][2];
  logic [1:0]  m_ack   [2];
  logic        mem_en  [2];
  logic        mem_wen [2];
  logic        busy    [2];
  logic [31:0] mem_addr  [2];
  logic [31:0] mem_wdata [2];
  logic [31:0] mem_rdata;

  int          cyc;
  logic [31:0] hist [int];   // mem_rdata value held during each cycle
  int          n_total;
  int          n_bad;
  int          last_m [2];
  logic [31:0] rd_exp [2][2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    dmem_arbiter #(
      .AW     (32),
      .DW     (32),
      .MEM_LAT((gi == 0) ? 1 : 3),
      .PRIO_M0((gi == 0) ? 0 : 1)
    ) u_dut (
      .clk      (clk),
      .rstn     (rstn),
      .m0_req   (m_req[gi][0]),
      .m0_wen   (m_wen[gi][0]),
      .m0_addr  (m_addr[gi][0]),
      .m0_wdata (m_wdata[gi][0]),
      .m0_ack   (m_ack[gi][0]),
      .m0_rdata (m_rdata[gi][0]),
      .m1_req   (m_req[gi][1]),
      .m1_wen   (m_wen[gi][1]),
      .m1_addr  (m_addr[gi][1]),
      .m1_wdata (m_wdata[gi][1]),
      .m1_ack   (m_ack[gi][1]),
      .m1_rdata (m_rdata[gi][1]),
      .mem_en   (mem_en[gi]),
      .mem_wen  (mem_wen[gi]),
      .mem_addr (mem_addr[gi]),
      .mem_wdata(mem_wdata[gi]),
      .mem_rdata(mem_rdata),
      .busy     (busy[gi])
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle counter plus a memory whose read data changes every cycle.
  initial begin
    cyc       = 0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      mem_rdata = $urandom;
      hist[cyc] = mem_rdata;
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  // Arbitration rule: single requester wins; ties to m0 in priority mode, else not-last.
  function automatic int pick(input logic [1:0] p, input int last, input bit prio);
    if (p == 2'b01) return 0;
    if (p == 2'b10) return 1;
    return prio ? 0 : 1 - last;
  endfunction

  // wmode: 0 random, 1 read only, 2 write only
  task automatic new_payload(input int inst, input int m, input int wmode);
    m_wen[inst][m]   = (wmode == 1) ? 1'b0 : (wmode == 2) ? 1'b1 : 1'($urandom_range(1));
    m_addr[inst][m]  = $urandom;
    m_wdata[inst][m] = $urandom;
  endtask

  task automatic check_zero(input int inst);
    check_eq("rst_busy", busy[inst], 0);
    check_eq("rst_mem_en", mem_en[inst], 0);
    check_eq("rst_mem_wen", mem_wen[inst], 0);
    check_eq("rst_ack", m_ack[inst], 0);
    check_eq("rst_mem_addr", mem_addr[inst], 0);
    check_eq("rst_mem_wdata", mem_wdata[inst], 0);
    check_eq("rst_rdata0", m_rdata[inst][0], 0);
    check_eq("rst_rdata1", m_rdata[inst][1], 0);
  endtask

  // Raise the masters in mask, serve until all drop. With hold set, acked masters
  // immediately re-request until nxfer transfers have completed.
  task automatic run_round(input int inst, input logic [1:0] mask, input bit hold,
                           input int nxfer, input int wmode);
    logic [1:0]  pend;
    logic [1:0]  exp_ack;
    logic [31:0] ea, ed;
    logic        ew;
    bit          prio, early;
    int          g, a, w, lat, x;
    lat = (inst == 0) ? 1 : 3;
    prio = (inst == 1);
    @(negedge clk);
    pend = mask;
    for (int m = 0; m < 2; m++) if (mask[m]) new_payload(inst, m, wmode);
    m_req[inst] = mask;
    g = cyc + 1;
    x = 0;
    while (pend != 2'b00) begin
      w = pick(pend, last_m[inst], prio);
      last_m[inst] = w;
      ew = m_wen[inst][w];
      ea = m_addr[inst][w];
      ed = m_wdata[inst][w];
      a = ew ? g + 1 : g + 1 + lat;
      early = !hold && ($urandom_range(1) == 1);
      while (cyc < a) begin
        @(negedge clk);
        exp_ack = (cyc == a) ? 2'(1 << w) : 2'b00;
        check_eq("mem_en", mem_en[inst], (cyc == g));
        check_eq("mem_wen", mem_wen[inst], (cyc == g) && ew);
        check_eq("busy", busy[inst], 1);
        check_eq("ack", m_ack[inst], exp_ack);
        check_eq("mem_addr", mem_addr[inst], ea);
        check_eq("mem_wdata", mem_wdata[inst], ed);
        if (cyc == g) begin
          // Payload changes and an early req drop after the grant must not matter.
          m_addr[inst][w]  = $urandom;
          m_wdata[inst][w] = $urandom;
          if (early) m_req[inst][w] = 1'b0;
        end
      end
      if (!ew) rd_exp[inst][w] = hist[g + lat];
      check_eq("rdata_m0", m_rdata[inst][0], rd_exp[inst][0]);
      check_eq("rdata_m1", m_rdata[inst][1], rd_exp[inst][1]);
      if (hold && x < nxfer - 1) begin
        new_payload(inst, w, wmode);
      end else begin
        pend[w] = 1'b0;
        m_req[inst][w] = 1'b0;
      end
      x++;
      @(negedge clk);
      check_eq("idle_busy", busy[inst], 0);
      check_eq("idle_ack", m_ack[inst], 0);
      check_eq("idle_mem_en", mem_en[inst], 0);
      g = a + 2;
    end
  endtask

  task automatic reset_mid_wait();
    int g;
    @(negedge clk);
    new_payload(1, 0, 1);
    m_req[1] = 2'b01;
    g = cyc + 1;
    while (cyc < g + 1) @(negedge clk);
    check_eq("wait_busy", busy[1], 1);
    #2;
    rstn = 1'b0;
    #1;
    check_zero(1);
    check_zero(0);
    m_req[1] = 2'b00;
    for (int i = 0; i < 2; i++) begin
      last_m[i] = 1;
      rd_exp[i][0] = '0;
      rd_exp[i][1] = '0;
    end
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    repeat (6) begin
      @(negedge clk);
      check_eq("post_rst_ack", m_ack[1], 0);
      check_eq("post_rst_busy", busy[1], 0);
    end
  endtask

  initial begin
    logic [1:0] mk;
    n_total = 0;
    n_bad   = 0;
    rstn    = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_req[i]  = 2'b00;
      m_wen[i]  = 2'b00;
      last_m[i] = 1;
      for (int m = 0; m < 2; m++) begin
        m_addr[i][m]  = '0;
        m_wdata[i][m] = '0;
        rd_exp[i][m]  = '0;
      end
    end
    repeat (3) @(negedge clk);
    check_zero(0);
    check_zero(1);
    rstn = 1'b1;

    run_round(0, 2'b01, 1'b0, 1, 1);   // single m0 read
    run_round(0, 2'b10, 1'b0, 1, 2);   // single m1 write
    run_round(0, 2'b11, 1'b1, 8, 1);   // continuous reads, alternating grants
    repeat (25) begin
      mk = 2'($urandom_range(3, 1));
      run_round(0, mk, 1'b0, 1, 0);
    end

    run_round(1, 2'b11, 1'b1, 6, 1);   // m0 keeps winning while it holds req
    repeat (25) begin
      mk = 2'($urandom_range(3, 1));
      run_round(1, mk, 1'b0, 1, 0);
    end

    run_round(0, 2'b01, 1'b0, 1, 0);   // leaves last grant at m0
    reset_mid_wait();
    run_round(0, 2'b11, 1'b0, 1, 0);   // reset last grant makes m0 win the tie
    run_round(1, 2'b01, 1'b0, 1, 1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
